// File: rtl/replay_sched.sv
// -----------------------------------------------------------------------------
// replay_sched
//
// Replay scheduler for a link-layer retry buffer. Tracks which buffer slots
// hold transmitted but unacknowledged TLPs, retires them when an ACK/NAK
// covers their sequence numbers, and walks the surviving slots beat by beat
// when a NAK or a replay-timer expiry asks for a retransmission. Four replays
// in a row without forward progress raise a one-cycle retrain request.
//
// Ports
//   clk            sole clock, rising edge
//   reset_n        asynchronous active-low reset
//   we / wr_seq    offer one new TLP (and its 12-bit sequence number)
//   ack_nack       DLLP type: 2'b01 ACK, 2'b10 NAK, otherwise none
//   ack_seq        sequence number carried by the ACK/NAK
//   tim_out        replay timer expiry pulse
//   busy_n         downstream can take a beat this cycle (1 = free)
//   ready          new TLP accepted this cycle when we=1
//   wr_slot        slot the buffer writes the accepted TLP into
//   rd_en          buffer beat read strobe
//   rd_slot        slot being replayed (oldest slot outside replay)
//   rd_beat        beat index within the slot (word-mux select)
//   replay_active  high while replaying
//   full / empty   outstanding count is DEPTH / zero
//   outstanding    number of unacknowledged slots
//   retrain        one-cycle pulse: replay limit exceeded
// -----------------------------------------------------------------------------
module replay_sched #(
    parameter int DEPTH = 16,
    parameter int BEATS = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       we,
    input  logic [11:0]                wr_seq,
    input  logic [1:0]                 ack_nack,
    input  logic [11:0]                ack_seq,
    input  logic                       tim_out,
    input  logic                       busy_n,
    output logic                       ready,
    output logic [$clog2(DEPTH)-1:0]   wr_slot,
    output logic                       rd_en,
    output logic [$clog2(DEPTH)-1:0]   rd_slot,
    output logic [3:0]                 rd_beat,
    output logic                       replay_active,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       retrain
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PURGE  = 2'd1;
    localparam logic [1:0] ST_REPLAY = 2'd2;

    localparam logic [1:0] DLLP_ACK = 2'b01;
    localparam logic [1:0] DLLP_NAK = 2'b10;

    // Registered state
    logic [1:0]       state_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       replay_num_r;
    logic             pend_replay_r;
    logic [11:0]      latched_seq_r;
    logic [PTR_W-1:0] rep_slot_r;
    logic [PTR_W-1:0] rep_idx_r;
    logic [3:0]       rep_beat_r;
    logic             retrain_r;
    logic [11:0]      seq_table [DEPTH];

    // Next-state values
    logic [1:0]       state_s;
    logic [PTR_W-1:0] wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_s;
    logic [CNT_W-1:0] cnt_s;
    logic [1:0]       replay_num_s;
    logic             pend_replay_s;
    logic [11:0]      latched_seq_s;
    logic [PTR_W-1:0] rep_slot_s;
    logic [PTR_W-1:0] rep_idx_s;
    logic [3:0]       rep_beat_s;
    logic             retrain_s;
    logic             write_s;
    logic             start_replay_s;

    logic             full_s;
    logic             empty_s;
    logic             ready_s;
    logic             dllp_s;
    logic [11:0]      purge_diff_s;
    logic             purge_hit_s;
    logic             last_slot_s;

    // Status flags derived from the outstanding count
    always_comb begin
        full_s  = (cnt_r == CNT_W'(DEPTH));
        empty_s = (cnt_r == CNT_W'(0));
        ready_s = (state_r == ST_IDLE) && !full_s;
        dllp_s  = (ack_nack == DLLP_ACK) || (ack_nack == DLLP_NAK);
        // The oldest slot is covered by the ACK/NAK when it lies in the
        // half-window at or behind the acknowledged sequence number.
        purge_diff_s = latched_seq_r - seq_table[rd_ptr_r];
        purge_hit_s  = !empty_s && !purge_diff_s[11];
        last_slot_s  = ({1'b0, rep_idx_r} == (cnt_r - CNT_W'(1)));
    end

    // Next-state logic for the IDLE / PURGE / REPLAY machine
    always_comb begin
        state_s        = state_r;
        wr_ptr_s       = wr_ptr_r;
        rd_ptr_s       = rd_ptr_r;
        cnt_s          = cnt_r;
        replay_num_s   = replay_num_r;
        pend_replay_s  = pend_replay_r;
        latched_seq_s  = latched_seq_r;
        rep_slot_s     = rep_slot_r;
        rep_idx_s      = rep_idx_r;
        rep_beat_s     = rep_beat_r;
        retrain_s      = 1'b0;
        write_s        = 1'b0;
        start_replay_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (dllp_s) begin
                    latched_seq_s = ack_seq;
                    pend_replay_s = (ack_nack == DLLP_NAK);
                    state_s       = ST_PURGE;
                end else if (tim_out) begin
                    start_replay_s = !empty_s;
                end else if (we && ready_s) begin
                    write_s  = 1'b1;
                    wr_ptr_s = wr_ptr_r + PTR_W'(1);
                    cnt_s    = cnt_r + CNT_W'(1);
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_PURGE: begin
                if (purge_hit_s) begin
                    rd_ptr_s     = rd_ptr_r + PTR_W'(1);
                    cnt_s        = cnt_r - CNT_W'(1);
                    replay_num_s = 2'd0;
                end else if (pend_replay_r && !empty_s) begin
                    start_replay_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_REPLAY: begin
                if (busy_n) begin
                    if (rep_beat_r == 4'(BEATS - 1)) begin
                        rep_beat_s = 4'd0;
                        if (last_slot_s) begin
                            state_s = ST_IDLE;
                        end else begin
                            rep_slot_s = rep_slot_r + PTR_W'(1);
                            rep_idx_s  = rep_idx_r + PTR_W'(1);
                        end
                    end else begin
                        rep_beat_s = rep_beat_r + 4'd1;
                    end
                end else begin
                    rep_beat_s = rep_beat_r;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Replay entry: restart the walk at the oldest slot and bump the
        // consecutive-replay counter; the fourth in a row requests retrain
        // but the replay itself still goes ahead.
        if (start_replay_s) begin
            state_s    = ST_REPLAY;
            rep_slot_s = rd_ptr_r;
            rep_idx_s  = PTR_W'(0);
            rep_beat_s = 4'd0;
            if (replay_num_r == 2'd3) begin
                replay_num_s = 2'd0;
                retrain_s    = 1'b1;
            end else begin
                replay_num_s = replay_num_r + 2'd1;
            end
        end else begin
            rep_slot_s = rep_slot_s;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            cnt_r         <= '0;
            replay_num_r  <= 2'd0;
            pend_replay_r <= 1'b0;
            latched_seq_r <= 12'd0;
            rep_slot_r    <= '0;
            rep_idx_r     <= '0;
            rep_beat_r    <= 4'd0;
            retrain_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            wr_ptr_r      <= wr_ptr_s;
            rd_ptr_r      <= rd_ptr_s;
            cnt_r         <= cnt_s;
            replay_num_r  <= replay_num_s;
            pend_replay_r <= pend_replay_s;
            latched_seq_r <= latched_seq_s;
            rep_slot_r    <= rep_slot_s;
            rep_idx_r     <= rep_idx_s;
            rep_beat_r    <= rep_beat_s;
            retrain_r     <= retrain_s;
        end
    end

    // Sequence-number table; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (write_s) begin
            seq_table[wr_ptr_r] <= wr_seq;
        end
    end

    // Output mapping
    always_comb begin
        ready         = ready_s;
        wr_slot       = wr_ptr_r;
        full          = full_s;
        empty         = empty_s;
        outstanding   = cnt_r;
        retrain       = retrain_r;
        replay_active = (state_r == ST_REPLAY);
        if (state_r == ST_REPLAY) begin
            rd_en   = busy_n;
            rd_slot = rep_slot_r;
            rd_beat = rep_beat_r;
        end else begin
            rd_en   = 1'b0;
            rd_slot = rd_ptr_r;
            rd_beat = 4'd0;
        end
    end

endmodule

// File: tb/tb_replay_sched.sv
// -----------------------------------------------------------------------------
// tb_replay_sched
//
// Directed testbench for replay_sched: retain/ACK purge, NAK replay, throttled
// replay, retrain limit and its clearing, full buffer with sequence wrap,
// and reset in the middle of a replay. Inputs change on the falling edge and
// outputs are sampled there, away from the rising active edge.
// -----------------------------------------------------------------------------
module tb_replay_sched;

    logic        clk;
    logic        reset_n;
    logic        we;
    logic [11:0] wr_seq;
    logic [1:0]  ack_nack;
    logic [11:0] ack_seq;
    logic        tim_out;
    logic        busy_n;
    logic        ready;
    logic [3:0]  wr_slot;
    logic        rd_en;
    logic [3:0]  rd_slot;
    logic [3:0]  rd_beat;
    logic        replay_active;
    logic        full;
    logic        empty;
    logic [4:0]  outstanding;
    logic        retrain;

    int checks   = 0;
    int failures = 0;

    replay_sched #(.DEPTH(16), .BEATS(10)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .we            (we),
        .wr_seq        (wr_seq),
        .ack_nack      (ack_nack),
        .ack_seq       (ack_seq),
        .tim_out       (tim_out),
        .busy_n        (busy_n),
        .ready         (ready),
        .wr_slot       (wr_slot),
        .rd_en         (rd_en),
        .rd_slot       (rd_slot),
        .rd_beat       (rd_beat),
        .replay_active (replay_active),
        .full          (full),
        .empty         (empty),
        .outstanding   (outstanding),
        .retrain       (retrain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: through the rising edge to the next falling edge
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_tlp(input logic [11:0] s, input logic [3:0] exp_slot);
        check("wr_ready", ready, 1);
        check("wr_slot", wr_slot, exp_slot);
        we     = 1'b1;
        wr_seq = s;
        cyc();
        we     = 1'b0;
    endtask

    // ACK, then wait for the purge to finish; reports rd_en pulses seen
    task automatic ack_purge(input logic [11:0] s, output int pulses);
        ack_nack = 2'b01;
        ack_seq  = s;
        cyc();
        ack_nack = 2'b00;
        pulses   = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready) break;
            if (rd_en) pulses++;
            cyc();
        end
        check("ack_done", ready, 1);
    endtask

    // Follow a replay to its end, checking every beat against the expected order
    task automatic observe(input logic [3:0] first_slot, input int nslots,
                           input bit toggle, output int retr);
        int beat;
        int got;
        logic [3:0] slot;
        beat = 0;
        got  = 0;
        slot = first_slot;
        retr = 0;
        for (int i = 0; i < 40; i++) begin
            if (replay_active) break;
            check("pre_rd_en", rd_en, 0);
            cyc();
        end
        check("rep_start", replay_active, 1);
        for (int i = 0; i < 400; i++) begin
            busy_n = toggle ? ~i[0] : 1'b1;
            #1;
            if (!replay_active) break;
            if (retrain) retr++;
            check("rd_en_busy", rd_en, busy_n);
            if (rd_en) begin
                check("rep_slot", rd_slot, slot);
                check("rep_beat", rd_beat, beat);
                got++;
                beat++;
                if (beat == 10) begin
                    beat = 0;
                    slot = slot + 4'd1;
                end
            end
            cyc();
        end
        busy_n = 1'b1;
        check("rep_pulses", got, 10 * nslots);
        check("rep_end", replay_active, 0);
    endtask

    task automatic timer_replay(input logic [3:0] first_slot, input int nslots,
                                input int exp_retr);
        int r;
        tim_out = 1'b1;
        cyc();
        tim_out = 1'b0;
        observe(first_slot, nslots, 1'b0, r);
        check("retrain_cnt", r, exp_retr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_active"}, replay_active, 0);
        check({tag, "_retrain"}, retrain, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_outst"}, outstanding, 0);
        check({tag, "_wr_slot"}, wr_slot, 0);
        check({tag, "_rd_slot"}, rd_slot, 0);
        check({tag, "_rd_beat"}, rd_beat, 0);
    endtask

    initial begin
        int p;
        int r;
        reset_n  = 1'b0;
        we       = 1'b0;
        wr_seq   = 12'd0;
        ack_nack = 2'b00;
        ack_seq  = 12'd0;
        tim_out  = 1'b0;
        busy_n   = 1'b1;
        #1;
        check_reset_outputs("rst");
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();

        // Retain seq 0..4, ACK 2 retires three of them without reading
        for (int k = 0; k < 5; k++) write_tlp(12'(k), 4'(k));
        check("outst5", outstanding, 5);
        ack_purge(12'd2, p);
        check("purge_no_rd", p, 0);
        check("outst2", outstanding, 2);
        check("rd_ptr3", rd_slot, 3);
        check("wr_ptr5", wr_slot, 5);
        ack_purge(12'd4, p);
        check("empty_after_ack4", empty, 1);
        check("rd_ptr5", rd_slot, 5);

        // NAK after three TLPs: one purged, remaining two replayed
        write_tlp(12'd5, 4'd5);
        write_tlp(12'd6, 4'd6);
        write_tlp(12'd7, 4'd7);
        ack_nack = 2'b10;
        ack_seq  = 12'd5;
        cyc();
        ack_nack = 2'b00;
        observe(4'd6, 2, 1'b0, r);
        check("nak_retrain", r, 0);
        check("nak_outst", outstanding, 2);
        check("nak_ready", ready, 1);

        // Timer replay with downstream busy every other cycle
        tim_out = 1'b1;
        cyc();
        tim_out = 1'b0;
        observe(4'd6, 2, 1'b1, r);
        check("thr_outst", outstanding, 2);

        // ACK 6 retires slot 6 and clears the replay count
        ack_purge(12'd6, p);
        check("outst1", outstanding, 1);
        timer_replay(4'd7, 1, 0);
        timer_replay(4'd7, 1, 0);
        timer_replay(4'd7, 1, 0);
        timer_replay(4'd7, 1, 1);

        // Two more replays, then a purging ACK must restart the count
        write_tlp(12'd8, 4'd8);
        timer_replay(4'd7, 2, 0);
        timer_replay(4'd7, 2, 0);
        ack_purge(12'd7, p);
        check("outst_after_ack7", outstanding, 1);
        timer_replay(4'd8, 1, 0);
        timer_replay(4'd8, 1, 0);
        timer_replay(4'd8, 1, 0);
        ack_purge(12'd8, p);
        check("empty_after_ack8", empty, 1);

        // Timer expiry with nothing outstanding is ignored
        tim_out = 1'b1;
        cyc();
        tim_out = 1'b0;
        check("tim_empty_active", replay_active, 0);
        check("tim_empty_ready", ready, 1);

        // Fill all 16 slots with sequence numbers wrapping through 4095
        for (int k = 0; k < 16; k++) write_tlp(12'((4090 + k) % 4096), 4'(9 + k));
        check("full", full, 1);
        check("full_ready", ready, 0);
        we     = 1'b1;
        wr_seq = 12'd123;
        cyc();
        we     = 1'b0;
        check("full_ignore_outst", outstanding, 16);
        check("full_ignore_slot", wr_slot, 9);
        ack_purge(12'd3, p);
        check("wrap_outst", outstanding, 6);
        check("wrap_rd_slot", rd_slot, 3);
        check("wrap_full", full, 0);

        // Reset in the middle of a replay, at beat 5
        tim_out = 1'b1;
        cyc();
        tim_out = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rd_beat == 4'd5) break;
            cyc();
        end
        check("mid_beat5", rd_beat, 5);
        check("mid_rd_en", rd_en, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        cyc();
        check("mid_hold_rd_en", rd_en, 0);
        reset_n = 1'b1;
        cyc();
        check("post_rd_en", rd_en, 0);
        check("post_empty", empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
